// File: rtl/mod_mul_pkg.sv
// Shared definitions for the modulo multiplier datapath: modulus select codes,
// accumulator state encoding and the modulus lookup.
package mod_mul_pkg;

    localparam logic [1:0] MOD_M1  = 2'b00;  // 2^N - 1
    localparam logic [1:0] MOD_P2  = 2'b01;  // 2^N
    localparam logic [1:0] MOD_P1  = 2'b10;  // 2^N + 1
    localparam logic [1:0] MOD_RSV = 2'b11;  // reserved, behaves as 2^N

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } acc_state_t;

    // Returned on 32 bits; callers keep the low N+2 bits, which always hold M.
    function automatic logic [31:0] mod_value(input logic [1:0] sel, input int n);
        logic [31:0] base;
        base = 32'd1 << n;
        case (sel)
            MOD_M1:          return base - 32'd1;
            MOD_P1:          return base + 32'd1;
            MOD_P2, MOD_RSV: return base;
            default:         return base;
        endcase
    endfunction

endpackage

// File: rtl/mod_acc_if.sv
// Product input stream and result output stream of the modulo accumulator.
// master = producer/consumer side, slave = accumulator side.
interface mod_acc_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mod_add.sv
// Combinational (a + b) mod M for operands already reduced below M.
// A single conditional subtract suffices because a + b < 2M.
module mod_add #(
    parameter int N = 8
) (
    input  logic [N:0]   a_i,
    input  logic [N:0]   b_i,
    input  logic [N+1:0] m_i,
    output logic [N:0]   y_o
);
    logic [N+1:0] sum;

    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y_o = (N+1)'((sum >= m_i) ? (sum - m_i) : sum);
    end
endmodule

// File: rtl/mod_accumulator.sv
// Sums a frame of LEN reduced products modulo M and holds the result behind
// a valid/ready handshake.
//   state    | meaning
//   ST_IDLE  | waiting for start; no input accepted, no result offered
//   ST_ACCUM | accepting products until LEN have been transferred
//   ST_DONE  | result offered on out_data until out_ready
module mod_accumulator
    import mod_mul_pkg::*;
#(
    parameter int N     = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mod_sel,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             range_err,
    mod_acc_if.slave         bus
);
    acc_state_t       state_q;
    logic [N:0]       acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic [LEN_W-1:0] len_q;
    logic             range_err_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [2*N-1:0]   out_data_q;

    logic [N+1:0]     m;
    logic             in_range;
    logic             accept;
    logic             last;
    logic [N:0]       sum;
    logic [N:0]       acc_d;

    always_comb begin
        m        = (N+2)'(mod_value(sel_q, N));
        in_range = bus.in_data < (2*N)'(m);
        accept   = bus.in_valid && in_ready_q;
        last     = (cnt_q == len_q - LEN_W'(1));
    end

    mod_add #(.N(N)) u_mod_add (
        .a_i (acc_q),
        .b_i (bus.in_data[N:0]),
        .m_i (m),
        .y_o (sum)
    );

    // Out-of-range products still count toward the frame but leave acc alone.
    assign acc_d = in_range ? sum : acc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            len_q       <= '0;
            range_err_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sel_q       <= mod_sel;
                        len_q       <= len;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        range_err_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (len == '0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                        end else begin
                            state_q    <= ST_ACCUM;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        acc_q <= acc_d;
                        if (!in_range) begin
                            range_err_q <= 1'b1;
                        end
                        if (last) begin
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= (2*N)'(acc_d);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        out_data_q  <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign range_err     = range_err_q;
endmodule

// File: doc/mod_accumulator.md
Name: mod_accumulator

Overview:
Downstream stage of the modulo multiplier. It consumes a stream of already-reduced products (P, qualified by done) and sums a frame of LEN of them modulo the same modulus selected by mod_sel. It holds the frame result behind a valid/ready handshake. Typical use is a modular dot product (sum of A_i*B_i mod M).

Parameters:
N, 8, operand width of the upstream multiplier; products arrive on 2N bits.
LEN_W, 4, width of the frame-length input; maximum frame length is 2^LEN_W-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-low reset.
start  input  1  frame start pulse; sampled only in IDLE.
mod_sel  input  2  modulus select, latched on start: 00 -> 2^N-1, 01 -> 2^N, 10 -> 2^N+1, 11 -> 2^N.
len  input  LEN_W  number of products in the frame, latched on start.
in_valid  input  1  product valid; driven by the multiplier done.
in_data  input  2N  reduced product (P); only bits [N:0] are significant.
in_ready  output  1  block accepts a product this cycle.
out_valid  output  1  frame result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  2N  frame sum mod M, zero-extended.
busy  output  1  high in any state other than IDLE.
range_err  output  1  sticky flag: a product arrived with in_data >= M.

Behaviour:
- Reset, when rst=0 at a clock edge:
  - state goes to IDLE.
  - acc, cnt, latched mod_sel and latched len all clear to 0.
  - out_valid=0, out_data=0, in_ready=0, busy=0, range_err=0.
  - Reset has priority over every other event, including mid-frame. A partially accumulated sum is discarded.
- States are IDLE, ACCUM and DONE.
- IDLE:
  - in_ready=0 and out_valid=0.
  - On start=1: latch mod_sel and len, clear acc and cnt, clear range_err.
  - If len==0, go to DONE with acc=0. Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A transfer happens when in_valid and in_ready are both 1; cnt then increments.
  - If in_data >= M, set range_err and leave acc unchanged. The product still counts toward the frame.
  - Otherwise compute s = acc + in_data[N:0] on N+2 bits. If s >= M, then acc <= s - M; else acc <= s.
  - The transfer with cnt==len-1 moves to DONE in the same cycle. The result is therefore visible one cycle after the last accepted product.
  - start is ignored while in ACCUM.
- DONE:
  - out_valid=1 and out_data={zeros, acc}.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - When out_valid and out_ready are both 1, go to IDLE. A start in that same cycle is ignored, so the earliest next frame start is the following cycle.
  - in_ready=0, and start is ignored.
- Width rules:
  - acc is N+1 bits; its maximum is 2^N, which occurs for M=2^N+1.
  - Internal sum is N+2 bits.
  - M for mod_sel=01/11 is 2^N, so the reduction reduces to the acc low N bits.
- Invariant: acc < M at all times.

Decomposition:
- Shared package mod_mul_pkg holds:
  - mod_sel encodings as localparams (MOD_M1, MOD_P2, MOD_P1, MOD_RSV).
  - state encoding for IDLE/ACCUM/DONE.
  - function mod_value(sel, N) returning M on N+2 bits.
- One sub-module, mod_add: combinational (a + b) mod M, given a < M and b < M. It is reusable by the modulo reduction stage.
- The FSM, counter and handshake registers stay in mod_accumulator.

Test Plan:
- N=8, mod_sel=00 (M=255), len=2, products 200 then 100 -> out_data=45, out_valid one cycle after the 2nd accept, range_err=0.
- mod_sel=01 (M=256), len=3, products 200, 100, 255 -> out_data=43. Also mod_sel=10 (M=257), len=2, products 256, 256 -> out_data=255.
- len=0 with start -> DONE next cycle, out_data=0, in_ready never asserted.
- mod_sel=00, len=2, products 255 (out of range), 10 -> range_err=1, out_data=10. The next start clears range_err.
- Backpressure: hold out_ready=0 for 3 cycles -> out_valid and out_data stable. Pulse start during those cycles -> ignored. Raise out_ready -> IDLE next cycle.
- rst=0 after 1 of 3 products in ACCUM -> next cycle busy=0, in_ready=0, out_valid=0. A new frame with len=1 and product 7 gives out_data=7.
